upg_loader: RTL and testbench
=============================

Name: upg_loader

Overview:
- UART-side programming initiator. It consumes the byte stream from the board UART receiver and drives the upg_* write port of the instruction and data memories.
- It frames incoming bytes into per-region bursts, packs four bytes into one 32-bit word, and issues one write strobe per word with an auto-incrementing word address.
- It raises upg_done_o once the host sends the end command. The memories then hand their port back to the CPU clock domain.

Parameters:
- ADDR_W, 14, word-address width of each memory region
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes inside a frame before aborting
- CMD_IMEM, 8'h00, command byte selecting the instruction memory
- CMD_DMEM, 8'h01, command byte selecting the data memory
- CMD_END, 8'hFF, command byte ending the programming session

Ports:
- upg_clk_i  in  1  programming clock; all state is on its rising edge
- upg_rst_i  in  1  asynchronous, active-high reset
- rx_data_i  in  8  received byte from the UART receiver
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid in this cycle
- upg_wen_o  out  1  one-cycle memory write strobe
- upg_adr_o  out  ADDR_W+1  bit ADDR_W is the region select (0 = IMEM, 1 = DMEM); bits ADDR_W-1:0 are the word address
- upg_dat_o  out  32  write data word
- upg_done_o  out  1  session complete; sticky until reset
- busy_o  out  1  high while a region frame is in progress
- err_o  out  1  protocol error or timeout; sticky until reset

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = IDLE
  - all outputs 0
  - byte, word and timeout counters 0
  - region register 0
- Frame format: command byte, then count_lo, then count_hi (16-bit word count, little-endian), then count×4 data bytes.
- Data word packing is little-endian: the first byte lands in bits 7:0, the fourth in bits 31:24.
- States and transitions:
  - IDLE, on a byte:
    - CMD_IMEM or CMD_DMEM: latch the region → CNT_LO.
    - CMD_END → DONE.
    - Any other value → ERR.
  - CNT_LO: on a byte, latch the low count byte → CNT_HI.
  - CNT_HI: on a byte, form the 16-bit count.
    - count == 0 → IDLE, no writes.
    - count > 2^ADDR_W → ERR.
    - Otherwise clear the word address → DATA.
  - DATA, on each byte:
    - Shift the byte into the packing register and increment a 2-bit byte index.
    - When the fourth byte is accepted, in the next cycle:
      - upg_wen_o = 1 for exactly one cycle;
      - upg_dat_o = the packed word;
      - upg_adr_o = {region, word_addr};
      - word_addr increments afterwards.
    - After the last word's strobe → IDLE.
  - DONE: upg_done_o = 1; all bytes ignored; held until reset.
  - ERR: err_o = 1; all bytes ignored; held until reset. upg_done_o stays 0.
- Output hold and busy:
  - upg_adr_o and upg_dat_o hold their last values between strobes.
  - upg_wen_o is never high outside DATA.
  - busy_o is high in CNT_LO, CNT_HI and DATA.
- Timeout:
  - The counter increments every cycle while busy_o is high and rx_valid_i is low, and clears on any rx_valid_i.
  - Reaching TIMEOUT_CYC → ERR; any partial word is discarded with no strobe.
  - The timeout is inactive in IDLE, DONE and ERR.
- Throughput: back-to-back rx_valid_i on consecutive cycles is supported. A fourth byte in cycle n gives its strobe in cycle n+1, while byte 1 of the next word can be accepted in cycle n+1.
- Wrap-around: the word address never wraps, because the count check bounds it to 2^ADDR_W−1. A count of exactly 2^ADDR_W is legal and ends at address all-ones.
- Reset mid-frame: everything returns to the reset values immediately, with no strobe.
- Multiple region frames are allowed in any order before CMD_END; each frame restarts its address at 0.

Decomposition:
- Shared package:
  - command byte constants;
  - state enum (IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR);
  - region-select bit index.
- Sub-module upg_word_packer: byte shift register, 2-bit byte index and word_ready pulse, with a clear input used on timeout and frame start.
- FSM, counters and timeout stay in upg_loader.

Test Plan:
- IMEM load: bytes 00,02,00,11,22,33,44,AA,BB,CC,DD,FF → two strobes.
  - Strobe 1: adr = 15'h0000, dat = 32'h44332211.
  - Strobe 2: adr = 15'h0001, dat = 32'hDDCCBBAA.
  - Then upg_done_o = 1, err_o = 0.
- DMEM load, back-to-back bytes: 01,01,00,EF,BE,AD,DE with rx_valid_i high on every cycle → single strobe, adr = 15'h4000, dat = 32'hDEADBEEF, strobe exactly one cycle after the last byte.
- Zero count then end: 00,00,00,FF → no strobe, upg_done_o = 1; bytes after FF change nothing.
- Bad command 8'h37 → err_o = 1, upg_done_o = 0, no strobes; subsequent valid frames are ignored.
- Timeout (TIMEOUT_CYC = 16): 00,01,00,11,22 then 16 idle cycles → err_o = 1, no strobe; a mid-frame asynchronous reset instead clears all outputs immediately.
- Oversize: count 16'h4001 with ADDR_W = 14 → err_o = 1; count 16'h4000 gives 16384 strobes, the last at word address 14'h3FFF.

Source files
------------

// File: rtl/upg_loader_pkg.sv
// Shared definitions for the UART programming loader: command bytes,
// FSM state encoding and the default memory geometry.
package upg_loader_pkg;

  localparam int UPG_ADDR_W = 14;

  // Bit of upg_adr_o that selects the region: 0 = IMEM, 1 = DMEM.
  localparam int UPG_REGION_BIT = UPG_ADDR_W;

  localparam logic [7:0] UPG_CMD_IMEM = 8'h00;
  localparam logic [7:0] UPG_CMD_DMEM = 8'h01;
  localparam logic [7:0] UPG_CMD_END  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } upg_state_t;

endpackage

// File: rtl/upg_loader_if.sv
// Byte-stream input and memory write port of the programming loader.
// The loader connects to the slave side. The UART and memory side
// connects to the master side.
interface upg_loader_if #(
  parameter int ADDR_W = 14
);

  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          upg_wen_o;
  logic [ADDR_W:0] upg_adr_o;
  logic [31:0]   upg_dat_o;
  logic          upg_done_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  rx_data_i, rx_valid_i,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );

endinterface

// File: rtl/upg_word_packer.sv
// Packs four bytes little-endian into a 32-bit word. The first byte ends up
// in bits 7:0. word_ready pulses for one cycle after the fourth byte is taken.
// During that cycle, word_o still holds the complete word, even if the next
// byte is being shifted in at the same time.
module upg_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_o,
  output logic        word_ready
);

  logic [31:0] shreg_q;
  logic [1:0]  idx_q;
  logic        ready_q;

  // Shift bytes in from the top and flag completion of every fourth byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (clr) begin
        shreg_q <= '0;
        idx_q   <= '0;
      end else if (byte_valid) begin
        shreg_q <= {byte_data, shreg_q[31:8]};
        idx_q   <= idx_q + 2'd1;
        ready_q <= (idx_q == 2'd3);
      end
    end
  end

  assign word_o     = shreg_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/upg_loader.sv
// UART-side programming initiator. It frames the byte stream into
// per-region bursts, packs the data into words and issues one memory write
// strobe per word, using an auto-incrementing word address.
module upg_loader
  import upg_loader_pkg::*;
#(
  parameter int         ADDR_W      = UPG_ADDR_W,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] CMD_IMEM    = UPG_CMD_IMEM,
  parameter logic [7:0] CMD_DMEM    = UPG_CMD_DMEM,
  parameter logic [7:0] CMD_END     = UPG_CMD_END
) (
  input  logic         upg_clk_i,
  input  logic         upg_rst_i,
  upg_loader_if.slave  bus
);

  localparam int          TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  upg_state_t        state_q, state_d;
  logic              region_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       words_left_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [ADDR_W:0]   adr_hold_q;
  logic [31:0]       dat_hold_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic [15:0] frame_cnt;
  logic        busy, wen, last_word, timeout, frame_start, cmd_accept;
  logic        pk_valid, pk_clr, pk_ready;
  logic [31:0] pk_word;

  function automatic upg_state_t decode_cmd(input logic [7:0] b);
    if (b == CMD_IMEM || b == CMD_DMEM) return ST_CNT_LO;
    if (b == CMD_END) return ST_DONE;
    return ST_ERR;
  endfunction

  assign frame_cnt = {bus.rx_data_i, cnt_lo_q};
  assign busy      = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) || (state_q == ST_DATA);
  assign wen       = (state_q == ST_DATA) && pk_ready;
  assign last_word = wen && (words_left_q == 16'd1);
  // A command byte can arrive in the cycle of the final strobe. It is decoded
  // as if the loader were already idle, so the byte is not lost.
  assign cmd_accept  = bus.rx_valid_i && ((state_q == ST_IDLE) || last_word);
  assign timeout     = busy && !bus.rx_valid_i && !last_word &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign frame_start = bus.rx_valid_i && (state_q == ST_CNT_HI) &&
                       (frame_cnt != 16'd0) && ({16'd0, frame_cnt} <= MAX_WORDS);
  assign pk_valid    = bus.rx_valid_i && (state_q == ST_DATA) && !last_word;
  assign pk_clr      = frame_start || timeout;

  upg_word_packer u_packer (
    .clk        (upg_clk_i),
    .rst        (upg_rst_i),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_data  (bus.rx_data_i),
    .word_o     (pk_word),
    .word_ready (pk_ready)
  );

  // State register.
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode. A timeout overrides everything else while a frame is open.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.rx_valid_i) state_d = decode_cmd(bus.rx_data_i);
        ST_CNT_LO: if (bus.rx_valid_i) state_d = ST_CNT_HI;
        ST_CNT_HI: begin
          if (bus.rx_valid_i) begin
            if (frame_cnt == 16'd0) state_d = ST_IDLE;
            else if (frame_start)   state_d = ST_DATA;
            else                    state_d = ST_ERR;
          end
        end
        ST_DATA: begin
          if (last_word)
            state_d = bus.rx_valid_i ? decode_cmd(bus.rx_data_i) : ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Region, count, address, output-hold and timeout registers.
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      region_q     <= 1'b0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      word_addr_q  <= '0;
      adr_hold_q   <= '0;
      dat_hold_q   <= '0;
      to_cnt_q     <= '0;
    end else begin
      if (cmd_accept && (bus.rx_data_i == CMD_IMEM || bus.rx_data_i == CMD_DMEM))
        region_q <= (bus.rx_data_i == CMD_DMEM);
      if (state_q == ST_CNT_LO && bus.rx_valid_i)
        cnt_lo_q <= bus.rx_data_i;
      if (frame_start) begin
        words_left_q <= frame_cnt;
        word_addr_q  <= '0;
      end else if (wen) begin
        words_left_q <= words_left_q - 16'd1;
        word_addr_q  <= word_addr_q + 1'b1;
        adr_hold_q   <= {region_q, word_addr_q};
        dat_hold_q   <= pk_word;
      end
      if (bus.rx_valid_i || !busy || timeout) to_cnt_q <= '0;
      else                                    to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign bus.upg_wen_o  = wen;
  assign bus.upg_adr_o  = wen ? {region_q, word_addr_q} : adr_hold_q;
  assign bus.upg_dat_o  = wen ? pk_word : dat_hold_q;
  assign bus.upg_done_o = (state_q == ST_DONE);
  assign bus.err_o      = (state_q == ST_ERR);
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_upg_loader.sv
// Directed self-checking bench for upg_loader. Each scenario task drives a
// byte stream and compares strobes and flags against hand-computed values.
module tb_upg_loader;

  logic upg_clk_i = 1'b0;
  logic upg_rst_i = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  logic [14:0] adr_q[$];
  logic [31:0] dat_q[$];
  int          cyc_q[$];

  upg_loader_if #(.ADDR_W(14)) bus ();

  upg_loader #(
    .ADDR_W      (14),
    .TIMEOUT_CYC (16),
    .CMD_IMEM    (8'h00),
    .CMD_DMEM    (8'h01),
    .CMD_END     (8'hFF)
  ) dut (
    .upg_clk_i (upg_clk_i),
    .upg_rst_i (upg_rst_i),
    .bus       (bus)
  );

  // Free-running clock and cycle stamp.
  always #5 upg_clk_i = ~upg_clk_i;
  always @(posedge upg_clk_i) cyc++;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge upg_clk_i) begin
    if (bus.upg_wen_o === 1'b1) begin
      adr_q.push_back(bus.upg_adr_o);
      dat_q.push_back(bus.upg_dat_o);
      cyc_q.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(negedge upg_clk_i);
    upg_rst_i      = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (2) @(negedge upg_clk_i);
    upg_rst_i = 1'b0;
    adr_q.delete();
    dat_q.delete();
    cyc_q.delete();
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge upg_clk_i);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge upg_clk_i);
      bus.rx_valid_i = 1'b0;
    end
  endtask

  task automatic send_gap(input logic [7:0] b);
    drive_byte(b);
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (bus.upg_wen_o !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wen: got %b want 0", bus.upg_wen_o); end
    compared++;
    if (bus.upg_adr_o !== 15'h0000) begin mismatched++; $display("[TB] FAIL rst_adr: got %h want 0000", bus.upg_adr_o); end
    compared++;
    if (bus.upg_dat_o !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_dat: got %h want 0", bus.upg_dat_o); end
    compared++;
    if ({bus.upg_done_o, bus.busy_o, bus.err_o} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL rst_flags: got done/busy/err=%b want 000", {bus.upg_done_o, bus.busy_o, bus.err_o});
    end
  endtask

  task automatic test_imem_load();
    logic [7:0] bytes [12];
    bytes = '{8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
    do_reset();
    send_gap(bytes[0]);
    compared++;
    if (bus.busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL imem_busy: got %b want 1", bus.busy_o); end
    for (int i = 1; i < 12; i++) send_gap(bytes[i]);
    idle(2);
    compared++;
    if (adr_q.size() !== 2) begin
      mismatched++; $display("[TB] FAIL imem_strobes: got %0d want 2", adr_q.size());
    end else begin
      compared++;
      if (adr_q[0] !== 15'h0000 || dat_q[0] !== 32'h44332211) begin
        mismatched++; $display("[TB] FAIL imem_w0: got %h/%h want 0000/44332211", adr_q[0], dat_q[0]);
      end
      compared++;
      if (adr_q[1] !== 15'h0001 || dat_q[1] !== 32'hDDCCBBAA) begin
        mismatched++; $display("[TB] FAIL imem_w1: got %h/%h want 0001/ddccbbaa", adr_q[1], dat_q[1]);
      end
    end
    compared++;
    if ({bus.upg_done_o, bus.err_o, bus.busy_o} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL imem_done: got done/err/busy=%b want 100", {bus.upg_done_o, bus.err_o, bus.busy_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [7];
    int last_cyc;
    bytes = '{8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    for (int i = 0; i < 7; i++) drive_byte(bytes[i]);
    last_cyc = cyc;
    idle(4);
    compared++;
    if (adr_q.size() !== 1) begin
      mismatched++; $display("[TB] FAIL b2b_strobes: got %0d want 1", adr_q.size());
    end else begin
      compared++;
      if (adr_q[0] !== 15'h4000 || dat_q[0] !== 32'hDEADBEEF) begin
        mismatched++; $display("[TB] FAIL b2b_word: got %h/%h want 4000/deadbeef", adr_q[0], dat_q[0]);
      end
      compared++;
      if (cyc_q[0] !== last_cyc + 1) begin
        mismatched++; $display("[TB] FAIL b2b_latency: got cycle %0d want %0d", cyc_q[0], last_cyc + 1);
      end
    end
    compared++;
    if (bus.upg_dat_o !== 32'hDEADBEEF || bus.upg_adr_o !== 15'h4000 || bus.upg_wen_o !== 1'b0) begin
      mismatched++; $display("[TB] FAIL b2b_hold: got %h/%h wen=%b want 4000/deadbeef wen=0", bus.upg_adr_o, bus.upg_dat_o, bus.upg_wen_o);
    end
    compared++;
    if (bus.busy_o !== 1'b0 || bus.upg_done_o !== 1'b0) begin
      mismatched++; $display("[TB] FAIL b2b_idle: got busy=%b done=%b want 0/0", bus.busy_o, bus.upg_done_o);
    end
  endtask

  task automatic test_zero_then_end();
    logic [7:0] bytes [11];
    bytes = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 11; i++) send_gap(bytes[i]);
    idle(2);
    compared++;
    if (adr_q.size() !== 0) begin mismatched++; $display("[TB] FAIL zero_strobes: got %0d want 0", adr_q.size()); end
    compared++;
    if ({bus.upg_done_o, bus.err_o, bus.busy_o} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL zero_done: got done/err/busy=%b want 100", {bus.upg_done_o, bus.err_o, bus.busy_o});
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] bytes [9];
    bytes = '{8'h37, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    do_reset();
    for (int i = 0; i < 9; i++) send_gap(bytes[i]);
    idle(2);
    compared++;
    if ({bus.err_o, bus.upg_done_o, bus.busy_o} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL bad_flags: got err/done/busy=%b want 100", {bus.err_o, bus.upg_done_o, bus.busy_o});
    end
    compared++;
    if (adr_q.size() !== 0) begin mismatched++; $display("[TB] FAIL bad_strobes: got %0d want 0", adr_q.size()); end
  endtask

  task automatic test_timeout();
    logic [7:0] bytes [7];
    bytes = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 5; i++) drive_byte(bytes[i]);
    idle(16);
    compared++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      mismatched++; $display("[TB] FAIL to_early: got err=%b busy=%b want 0/1", bus.err_o, bus.busy_o);
    end
    idle(1);
    compared++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      mismatched++; $display("[TB] FAIL to_err: got err=%b busy=%b want 1/0", bus.err_o, bus.busy_o);
    end
    send_gap(8'h33);
    send_gap(8'h44);
    compared++;
    if (adr_q.size() !== 0) begin mismatched++; $display("[TB] FAIL to_strobes: got %0d want 0", adr_q.size()); end

    do_reset();
    for (int i = 0; i < 6; i++) drive_byte(bytes[i]);
    idle(1);
    compared++;
    if (bus.busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b want 1", bus.busy_o); end
    upg_rst_i = 1'b1;
    #1;
    compared++;
    if ({bus.upg_wen_o, bus.busy_o, bus.err_o, bus.upg_done_o} !== 4'b0000 || bus.upg_adr_o !== 15'h0 || bus.upg_dat_o !== 32'h0) begin
      mismatched++; $display("[TB] FAIL midrst_outs: got wen/busy/err/done=%b adr=%h dat=%h want 0000/0/0",
        {bus.upg_wen_o, bus.busy_o, bus.err_o, bus.upg_done_o}, bus.upg_adr_o, bus.upg_dat_o);
    end
    @(negedge upg_clk_i);
    upg_rst_i = 1'b0;
    for (int i = 0; i < 7; i++) drive_byte(bytes[i]);
    idle(3);
    compared++;
    if (adr_q.size() !== 1 || dat_q[0] !== 32'h44332211 || adr_q[0] !== 15'h0000) begin
      mismatched++; $display("[TB] FAIL midrst_reload: got n=%0d want 1 strobe 0000/44332211", adr_q.size());
    end
  endtask

  task automatic test_oversize();
    int bad;
    do_reset();
    send_gap(8'h00);
    send_gap(8'h01);
    send_gap(8'h40);
    compared++;
    if (bus.err_o !== 1'b1 || adr_q.size() !== 0) begin
      mismatched++; $display("[TB] FAIL over_err: got err=%b n=%0d want 1/0", bus.err_o, adr_q.size());
    end

    do_reset();
    drive_byte(8'h01);
    drive_byte(8'h00);
    drive_byte(8'h40);
    for (int i = 0; i < 65536; i++) drive_byte(8'(i));
    idle(3);
    compared++;
    if (adr_q.size() !== 16384) begin
      mismatched++; $display("[TB] FAIL full_strobes: got %0d want 16384", adr_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 16384; k++) if (adr_q[k] !== {1'b1, 14'(k)}) bad++;
      compared++;
      if (bad !== 0) begin mismatched++; $display("[TB] FAIL full_seq: got %0d out-of-sequence addresses want 0", bad); end
      compared++;
      if (dat_q[0] !== 32'h03020100) begin mismatched++; $display("[TB] FAIL full_first: got %h want 03020100", dat_q[0]); end
      compared++;
      if (adr_q[16383] !== 15'h7FFF || dat_q[16383] !== 32'hFFFEFDFC) begin
        mismatched++; $display("[TB] FAIL full_last: got %h/%h want 7fff/fffefdfc", adr_q[16383], dat_q[16383]);
      end
    end
    compared++;
    if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
      mismatched++; $display("[TB] FAIL full_idle: got busy=%b err=%b want 0/0", bus.busy_o, bus.err_o);
    end
    send_gap(8'hFF);
    compared++;
    if (bus.upg_done_o !== 1'b1) begin mismatched++; $display("[TB] FAIL full_done: got %b want 1", bus.upg_done_o); end
  endtask

  // Guard against a hung run.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    test_reset();
    test_imem_load();
    test_back_to_back();
    test_zero_then_end();
    test_bad_cmd();
    test_timeout();
    test_oversize();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
